delay_ram_write_arbiter: RTL and testbench



---
 rtl/delay_ram_write_arbiter_if.sv | 25 ++
 rtl/delay_ram_write_arbiter.sv | 93 +++++++++
 tb/tb_delay_ram_write_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/delay_ram_write_arbiter_if.sv
// delay_ram_write_arbiter_if: write-stream and RAM-port bundle for the delay RAM write arbiter
interface delay_ram_write_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 24
);
  logic [3:0]          I_WEA;
  logic [4*ADDR_W-1:0] I_WRITE_ADDR;
  logic [4*DATA_W-1:0] I_WRITE_DELAY;
  logic                I_ram_busy;
  logic                I_ovf_clr;
  logic                O_WEA;
  logic [ADDR_W+1:0]   O_WRITE_ADDR;
  logic [DATA_W-1:0]   O_WRITE_DELAY;
  logic [3:0]          O_pending;
  logic [3:0]          O_overflow;
  logic                O_idle;
  modport master (
    output I_WEA, I_WRITE_ADDR, I_WRITE_DELAY, I_ram_busy, I_ovf_clr,
    input  O_WEA, O_WRITE_ADDR, O_WRITE_DELAY, O_pending, O_overflow, O_idle
  );
  modport slave (
    input  I_WEA, I_WRITE_ADDR, I_WRITE_DELAY, I_ram_busy, I_ovf_clr,
    output O_WEA, O_WRITE_ADDR, O_WRITE_DELAY, O_pending, O_overflow, O_idle
  );
endinterface

// File: rtl/delay_ram_write_arbiter.sv
// delay_ram_write_arbiter: merges four buffered delay-table write streams onto one RAM write port; define ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest) instead of round-robin
module delay_ram_write_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 4
) (
  input logic I_clk_10M,
  input logic I_rst,
  delay_ram_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_W + DATA_W;
  logic [EW-1:0]     mem [4][DEPTH];
  logic [PW-1:0]     wp [4];
  logic [PW-1:0]     rp [4];
  logic [PW:0]       cnt [4];
  logic [3:0]        ne, full, pop, acc, ovf_set, ovf;
  logic [1:0]        base, gnt;
  logic              gnt_v, wea;
  logic [ADDR_W+1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [EW-1:0]     head;
`ifdef ARB_FIXED_PRIO_EN
  assign base = 2'd0;
`else
  logic [1:0] rr;
  assign base = rr;
  // round-robin pointer moves just past the channel that won
  always_ff @(posedge I_clk_10M)
    if (I_rst) rr <= 2'd0;
    else if (gnt_v) rr <= gnt + 2'd1;
`endif
  // occupancy flags from the registered counts
  always_comb
    for (int k = 0; k < 4; k++) begin
      ne[k]   = cnt[k] != '0;
      full[k] = cnt[k] == (PW+1)'(DEPTH);
    end
  // first non-empty channel searching upward from base; busy RAM blocks the grant
  always_comb begin
    gnt_v = 1'b0;
    gnt   = base;
    for (int i = 3; i >= 0; i--)
      if (ne[base + 2'(i)]) begin
        gnt_v = !bus.I_ram_busy;
        gnt   = base + 2'(i);
      end
  end
  // a full FIFO still accepts a push when it is popped in the same cycle
  always_comb
    for (int k = 0; k < 4; k++) begin
      pop[k]     = gnt_v && gnt == 2'(k);
      acc[k]     = bus.I_WEA[k] && (!full[k] || pop[k]);
      ovf_set[k] = bus.I_WEA[k] && full[k] && !pop[k];
    end
  // FIFO pointers wrap naturally; the count separates full from empty
  always_ff @(posedge I_clk_10M)
    for (int k = 0; k < 4; k++)
      if (I_rst) begin
        wp[k]  <= '0;
        rp[k]  <= '0;
        cnt[k] <= '0;
      end else begin
        wp[k]  <= wp[k] + PW'(acc[k]);
        rp[k]  <= rp[k] + PW'(pop[k]);
        cnt[k] <= cnt[k] + (PW+1)'(acc[k]) - (PW+1)'(pop[k]);
      end
  // FIFO storage, contents are don't-care until pointers make them visible
  always_ff @(posedge I_clk_10M)
    for (int k = 0; k < 4; k++)
      if (acc[k]) mem[k][wp[k]] <= {bus.I_WRITE_ADDR[k*ADDR_W +: ADDR_W], bus.I_WRITE_DELAY[k*DATA_W +: DATA_W]};
  assign head = mem[gnt][rp[gnt]];
  // output register: one-cycle strobe, address/data hold between writes
  always_ff @(posedge I_clk_10M)
    if (I_rst) begin
      wea   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      wea <= gnt_v;
      if (gnt_v) {waddr, wdata} <= {gnt, head};
    end
  // sticky drop flags; a new drop beats a simultaneous clear
  always_ff @(posedge I_clk_10M)
    if (I_rst) ovf <= '0;
    else ovf <= (bus.I_ovf_clr ? 4'd0 : ovf) | ovf_set;
  assign bus.O_WEA         = wea;
  assign bus.O_WRITE_ADDR  = waddr;
  assign bus.O_WRITE_DELAY = wdata;
  assign bus.O_pending     = ne;
  assign bus.O_overflow    = ovf;
  assign bus.O_idle        = ~|ne & ~wea;
endmodule

// File: tb/tb_delay_ram_write_arbiter.sv
// tb_delay_ram_write_arbiter: directed and random stimulus checked against a queue-based model
module tb_delay_ram_write_arbiter;
  localparam int AW = 11;
  localparam int DW = 24;
  localparam int DEPTH = 4;
  typedef logic [AW+DW-1:0] ent_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  delay_ram_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  delay_ram_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .I_clk_10M(clk),
    .I_rst(rst),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  ent_t q[4][$];
  int rr = 0;
  logic e_wea = 1'b0;
  logic [AW+1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  logic [3:0] e_ovf = '0;
  logic [4*AW-1:0] wa;
  logic [4*DW-1:0] wd;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  task automatic rnd();
    for (int k = 0; k < 4; k++) begin
      wa[k*AW +: AW] = AW'($urandom);
      wd[k*DW +: DW] = DW'($urandom);
    end
  endtask
  task automatic model_step(input logic [3:0] wea, input logic busy, input logic clr, input logic r);
    int g, c, base;
    ent_t e;
    logic [3:0] set;
    if (r) begin
      for (int k = 0; k < 4; k++) q[k].delete();
      rr = 0;
      e_wea = 1'b0;
      e_addr = '0;
      e_data = '0;
      e_ovf = '0;
      return;
    end
`ifdef ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = rr;
`endif
    g = -1;
    if (!busy)
      for (int i = 0; i < 4; i++) begin
        c = (base + i) % 4;
        if (g < 0 && q[c].size() > 0) g = c;
      end
    e_wea = (g >= 0);
    if (g >= 0) begin
      e = q[g].pop_front();
      e_addr = {2'(g), e[AW+DW-1:DW]};
      e_data = e[DW-1:0];
      rr = (g + 1) % 4;
    end
    set = '0;
    for (int k = 0; k < 4; k++)
      if (wea[k]) begin
        if (q[k].size() == DEPTH) set[k] = 1'b1;
        else q[k].push_back({wa[k*AW +: AW], wd[k*DW +: DW]});
      end
    e_ovf = (clr ? 4'd0 : e_ovf) | set;
  endtask
  task automatic cyc(input logic [3:0] wea, input logic busy, input logic clr, input logic r);
    logic [3:0] pend;
    bus.I_WEA = wea;
    bus.I_ram_busy = busy;
    bus.I_ovf_clr = clr;
    bus.I_WRITE_ADDR = wa;
    bus.I_WRITE_DELAY = wd;
    rst = r;
    @(posedge clk);
    model_step(wea, busy, clr, r);
    #1;
    for (int k = 0; k < 4; k++) pend[k] = q[k].size() > 0;
    chk("wea", 64'(bus.O_WEA), 64'(e_wea));
    chk("addr", 64'(bus.O_WRITE_ADDR), 64'(e_addr));
    chk("data", 64'(bus.O_WRITE_DELAY), 64'(e_data));
    chk("pending", 64'(bus.O_pending), 64'(pend));
    chk("overflow", 64'(bus.O_overflow), 64'(e_ovf));
    chk("idle", 64'(bus.O_idle), 64'(pend == 4'd0 && !e_wea));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rnd();
      cyc(4'd0, 1'b0, 1'b0, 1'b0);
    end
  endtask
  initial begin
    rnd();
    cyc(4'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_idle", 64'(bus.O_idle), 64'd1);
    chk("rst_wea", 64'(bus.O_WEA), 64'd0);
    idle(1);
    wa = '0;
    wd = '0;
    wa[AW +: AW] = 11'h005;
    wd[DW +: DW] = 24'h00ABCD;
    cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("single_wea", 64'(bus.O_WEA), 64'd1);
    chk("single_addr", 64'(bus.O_WRITE_ADDR), 64'({2'd1, 11'h005}));
    chk("single_data", 64'(bus.O_WRITE_DELAY), 64'h00ABCD);
    idle(1);
    chk("single_idle", 64'(bus.O_idle), 64'd1);
    for (int b = 0; b < 2; b++) begin
      rnd();
      cyc(4'hF, 1'b0, 1'b0, 1'b0);
      idle(6);
    end
    rnd();
    cyc(4'hF, 1'b0, 1'b0, 1'b0);
    rnd();
    cyc(4'h1, 1'b0, 1'b0, 1'b0);
    idle(7);
    for (int i = 0; i < 4; i++) begin
      rnd();
      cyc(4'b1000, 1'b1, 1'b0, 1'b0);
    end
    chk("bp_pending", 64'(bus.O_pending), 64'b1000);
    chk("bp_wea", 64'(bus.O_WEA), 64'd0);
    idle(6);
    for (int i = 0; i < 5; i++) begin
      rnd();
      cyc(4'b0100, 1'b1, 1'b0, 1'b0);
    end
    chk("ovf_set", 64'(bus.O_overflow), 64'b0100);
    rnd();
    cyc(4'd0, 1'b1, 1'b1, 1'b0);
    chk("ovf_clr", 64'(bus.O_overflow), 64'd0);
    idle(6);
    for (int i = 0; i < 4; i++) begin
      rnd();
      cyc(4'b0001, 1'b1, 1'b0, 1'b0);
    end
    rnd();
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("fullpop_ovf", 64'(bus.O_overflow), 64'd0);
    idle(7);
    for (int i = 0; i < 3; i++) begin
      rnd();
      cyc(4'b0001, 1'b1, 1'b0, 1'b0);
    end
    rnd();
    cyc(4'd0, 1'b0, 1'b0, 1'b1);
    chk("midrst_pending", 64'(bus.O_pending), 64'd0);
    idle(4);
    chk("midrst_idle", 64'(bus.O_idle), 64'd1);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] w;
      for (int k = 0; k < 4; k++) w[k] = $urandom_range(0, 9) < 4;
      rnd();
      cyc(w, $urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
    end
    idle(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
